// File: rtl/cpu_pkg.sv
// Shared encodings for the SlimProc instruction sequencer.
package cpu_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PC_SEL_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_INTERRUPT = 3'd5,
    S_FAULT     = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_INC    = 2'b00,
    PC_TARGET = 2'b01,
    PC_VECTOR = 2'b10
  } pc_sel_t;

  // One cycle worth of sequencer strobes, before reset gating.
  typedef struct packed {
    logic                fetch_req;
    logic                ir_load;
    logic                alu_enable;
    logic                dmem_read;
    logic                dmem_write;
    logic                reg_write_en;
    logic                pc_write;
    logic [PC_SEL_W-1:0] pc_sel;
    logic                int_ack;
    logic                fault;
  } strobe_t;

endpackage

// File: rtl/cpu_wait_timer.sv
// Memory-ready wait counter; flags the last allowed wait cycle so the FSM can fault.
module cpu_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout_c
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic             TIMEOUT_ON = (MEM_TIMEOUT != 0);

  logic [CNT_W-1:0] wait_cnt;

  // Counts consecutive waiting cycles; any ready or leaving a wait state restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!active || ready) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = TIMEOUT_ON & active & ~ready & (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with interrupt entry and bus timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                interrupt,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                cu_mem_read,
  input  logic                cu_mem_write,
  input  logic                cu_reg_write,
  input  logic                cu_jump,
  input  logic                cu_branch_taken,
  input  logic                cu_reti,
  output logic                fetch_req,
  output logic                ir_load,
  output logic                alu_enable,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                reg_write_en,
  output logic                pc_write,
  output logic [PC_SEL_W-1:0] pc_sel,
  output logic                int_ack,
  output logic                fault,
  output logic [STATE_W-1:0]  state
);

  state_t  state_q;
  state_t  state_d;
  logic    int_pending;
  logic    irq_en;
  logic    irq_en_d;
  logic    retire;
  logic    wait_active;
  logic    wait_ready;
  logic    timeout_c;
  strobe_t str;

  assign wait_active = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign wait_ready  = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  cpu_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (wait_active),
    .ready     (wait_ready),
    .timeout_c (timeout_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      irq_en  <= 1'b1;
    end else begin
      state_q <= state_d;
      irq_en  <= irq_en_d;
    end
  end

  // A new request in the acknowledge cycle must survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_pending <= 1'b0;
    end else if (interrupt) begin
      int_pending <= 1'b1;
    end else if (state_q == S_INTERRUPT) begin
      int_pending <= 1'b0;
    end
  end

  always_comb begin
    str      = '0;
    state_d  = state_q;
    irq_en_d = irq_en;
    retire   = 1'b0;

    case (state_q)
      S_FETCH: begin
        str.fetch_req = 1'b1;
        if (imem_ready) begin
          str.ir_load = 1'b1;
          state_d     = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        str.alu_enable = 1'b1;
        if (cu_mem_read || cu_mem_write) begin
          state_d = S_MEMORY;
        end else if (cu_reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEMORY: begin
        str.dmem_write = cu_mem_write;
        str.dmem_read  = ~cu_mem_write;
        if (dmem_ready) begin
          if (cu_reg_write) begin
            state_d = S_WRITEBACK;
          end else begin
            retire = 1'b1;
          end
        end else if (timeout_c) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        str.reg_write_en = 1'b1;
        retire           = 1'b1;
      end
      S_INTERRUPT: begin
        str.pc_write = 1'b1;
        str.pc_sel   = PC_VECTOR;
        str.int_ack  = 1'b1;
        irq_en_d     = 1'b0;
        state_d      = S_FETCH;
      end
      S_FAULT: str.fault = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Instruction boundary: update PC and decide whether to enter the handler.
    if (retire) begin
      str.pc_write = 1'b1;
      str.pc_sel   = (cu_jump || cu_branch_taken) ? PC_TARGET : PC_INC;
      if (cu_reti) begin
        irq_en_d = 1'b1;
      end
      state_d = (int_pending && irq_en_d) ? S_INTERRUPT : S_FETCH;
    end
  end

  assign fetch_req    = str.fetch_req    & ~reset;
  assign ir_load      = str.ir_load      & ~reset;
  assign alu_enable   = str.alu_enable   & ~reset;
  assign dmem_read    = str.dmem_read    & ~reset;
  assign dmem_write   = str.dmem_write   & ~reset;
  assign reg_write_en = str.reg_write_en & ~reset;
  assign pc_write     = str.pc_write     & ~reset;
  assign pc_sel       = reset ? PC_INC : str.pc_sel;
  assign int_ack      = str.int_ack      & ~reset;
  assign fault        = str.fault        & ~reset;
  assign state        = state_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the SlimProc CPU.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Qualifies the combinational decode strobes from the CPU control unit into one-cycle enables.
- Handles memory ready handshakes with a timeout, and interrupt entry/return.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for imem_ready/dmem_ready before FAULT; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- interrupt  in  1  level interrupt request.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- cu_mem_read  in  1  decoded load, from the control unit.
- cu_mem_write  in  1  decoded store.
- cu_reg_write  in  1  decoded register writeback.
- cu_jump  in  1  decoded jump.
- cu_branch_taken  in  1  resolved beq/bne condition.
- cu_reti  in  1  decoded return-from-interrupt.
- fetch_req  out  1  instruction fetch request.
- ir_load  out  1  latch instruction register.
- alu_enable  out  1  ALU operate strobe.
- dmem_read  out  1  data read request.
- dmem_write  out  1  data write request.
- reg_write_en  out  1  register file write strobe.
- pc_write  out  1  PC update strobe.
- pc_sel  out  2  PC source: 00 = PC+1, 01 = jump/branch target, 10 = interrupt vector.
- int_ack  out  1  interrupt accepted.
- fault  out  1  sticky bus-timeout fault.
- state  out  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, INTERRUPT=5, FAULT=6. Encoding 7 is unreachable and returns to FETCH.
- Reset, asynchronous: state=FETCH, wait_cnt=0, int_pending=0, irq_en=1. All outputs are 0 while reset is high. fetch_req rises in the first cycle after release.
- Outputs are combinational from state and the cu_* inputs. The cu_* inputs are stable from DECODE through retire, because IR is held.
- FETCH:
  - fetch_req=1 until imem_ready.
  - On the imem_ready cycle: ir_load=1, next state DECODE.
- DECODE: one cycle, no strobes, then EXECUTE.
- EXECUTE: alu_enable=1 for one cycle. Next state:
  - MEMORY if cu_mem_read or cu_mem_write;
  - else WRITEBACK if cu_reg_write;
  - else this cycle is the retire cycle.
- MEMORY:
  - dmem_write=1 if cu_mem_write; else dmem_read=1. A store wins if both are set.
  - Held until dmem_ready.
  - Then WRITEBACK if cu_reg_write, else retire in the dmem_ready cycle.
- WRITEBACK: reg_write_en=1 for one cycle, then retire.
- Retire cycle:
  - pc_write=1.
  - pc_sel=01 if cu_jump or cu_branch_taken, else 00.
  - If cu_reti: irq_en is set.
  - Next state INTERRUPT if int_pending and irq_en (post-RETI value counts), else FETCH.
- INTERRUPT:
  - One cycle: pc_write=1, pc_sel=10, int_ack=1.
  - Clears int_pending and irq_en (no nesting).
  - Then FETCH.
- int_pending:
  - Set on any cycle with interrupt=1.
  - Cleared only in INTERRUPT; set wins if interrupt is high in that same cycle.
  - Interrupts are taken only at instruction boundaries, never mid-access.
- Wait counter:
  - Increments each FETCH/MEMORY cycle without ready; clears on ready or on state change.
  - If MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT-1 and ready is low, next state is FAULT.
  - Ready arriving on that same cycle wins.
- FAULT: fault=1, all other strobes 0. Exited only by reset.
- Throughput: an ALU-only instruction takes 4 cycles with zero-wait memory: FETCH, DECODE, EXECUTE, WRITEBACK. A load takes 5.

Decomposition:
- Shared package cpu_pkg: state encodings, pc_sel encodings (PC_INC, PC_TARGET, PC_VECTOR).
- One natural sub-module, cpu_wait_timer: wait counter plus timeout compare, parameterised by MEM_TIMEOUT/CNT_W.
- Everything else lives in cpu_sequencer.

Test Plan:
- ADD (cu_reg_write=1, others 0), ready always 1 -> ir_load at cycle 0, alu_enable cycle 2, reg_write_en and pc_write with pc_sel=00 at cycle 3, fetch_req again at cycle 4.
- Load (cu_mem_read=1, cu_reg_write=1), dmem_ready delayed 3 cycles -> dmem_read high exactly 4 cycles, then reg_write_en for 1 cycle, pc_write.
- Jump (cu_jump=1, no mem/reg) -> pc_write with pc_sel=01 in the EXECUTE cycle, next state FETCH.
- interrupt pulsed 1 cycle during MEMORY -> access completes, retire, then INTERRUPT with int_ack=1 and pc_sel=10. A second interrupt is ignored until an instruction with cu_reti=1 retires, then taken.
- imem_ready held 0, MEM_TIMEOUT=15 -> FAULT entered after 15 FETCH cycles and stays sticky. Ready on the 15th cycle instead -> normal DECODE.
- reset asserted mid-MEMORY -> all outputs 0 immediately, state=FETCH. After release: fault=0, irq_en=1, fetch_req=1.
